node_mac_seq: RTL and testbench

NODE_MAC_SEQ -- requirements
Module: node_mac_seq

---
 rtl/node_pkg.sv | 18 +
 rtl/float_adder.sv | 82 ++++++++
 rtl/float_mult.sv | 52 +++++
 rtl/relu_fp32.sv | 11 +
 rtl/node_mac_seq.sv | 116 +++++++++++
 tb/tb_node_mac_seq.sv | 312 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/node_pkg.sv
// Shared types and constants for the FP32 neuron MAC sequencer.
// NODE_W packs element k at bits [32k+31:32k]; NODE_B is the bias.
package node_pkg;

  localparam int FP32_W = 32;
  localparam int NODE_N = 15;

  localparam logic [NODE_N*FP32_W-1:0] NODE_W = {
    32'h3F4CCCCD, 32'hBECCCCCD, 32'h3F8CCCCD, 32'hBFA66666, 32'h3F666666,
    32'h3DCCCCCD, 32'hC0200000, 32'h3F333333, 32'hBF19999A, 32'h3E4CCCCD,
    32'h40000000, 32'hBE800000, 32'h3FC00000, 32'hBF400000, 32'h3F000000
  };

  localparam logic [FP32_W-1:0] NODE_B = 32'h3E99999A;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

endpackage

// File: rtl/float_adder.sv
// Combinational FP32 adder with guard/round/sticky alignment, round-to-nearest-even.
// Out_test, shift and c_out expose the unrounded result, normalisation shift and carry.
module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic [31:0] Out_test,
  output logic [4:0]  shift,
  output logic        c_out
);

  logic              a_big;
  logic [31:0]       x, y;
  logic [7:0]        d;
  logic [26:0]       xm, ym, yal, n;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic              found;
  logic              rnd;
  logic [24:0]       m;
  logic [22:0]       frac;
  logic signed [9:0] e;
  logic              a_nan, b_nan, a_inf, b_inf;

  assign a_nan = (&a[30:23]) & (|a[22:0]);
  assign b_nan = (&b[30:23]) & (|b[22:0]);
  assign a_inf = (&a[30:23]) & ~(|a[22:0]);
  assign b_inf = (&b[30:23]) & ~(|b[22:0]);

  always_comb begin
    a_big = a[30:0] >= b[30:0];
    x     = a_big ? a : b;
    y     = a_big ? b : a;
    d     = x[30:23] - y[30:23];
    xm    = {1'b1, x[22:0], 3'b000};
    ym    = {1'b1, y[22:0], 3'b000};
    // Bits shifted past the round position collapse into the sticky bit.
    if (d >= 8'd27) begin
      yal = 27'd1;
    end else begin
      yal    = ym >> d;
      yal[0] = yal[0] | (|(ym & ~({27{1'b1}} << d)));
    end
    sum   = (x[31] == y[31]) ? ({1'b0, xm} + {1'b0, yal}) : ({1'b0, xm} - {1'b0, yal});
    c_out = sum[27];

    lz    = '0;
    found = 1'b0;
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = $signed({2'b00, x[30:23]}) + 10'sd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      n = sum[26:0] << lz;
      e = $signed({2'b00, x[30:23]}) - $signed({5'b0, lz});
    end
    shift    = lz;
    Out_test = {x[31], e[7:0], n[25:3]};

    rnd  = n[2] & (n[1] | n[0] | n[3]);
    m    = {1'b0, n[26:3]} + {24'b0, rnd};
    frac = m[24] ? m[23:1] : m[22:0];
    if (m[24]) e = e + 10'sd1;

    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) out = 32'h7FC00000;
    else if (a_inf)                                         out = a;
    else if (b_inf)                                         out = b;
    else if (a[30:23] == 8'd0 && b[30:23] == 8'd0)          out = {a[31] & b[31], 31'b0};
    else if (a[30:23] == 8'd0)                              out = b;
    else if (b[30:23] == 8'd0)                              out = a;
    else if (sum == 28'd0)                                  out = 32'h0;
    else if (e >= 10'sd255)                                 out = {x[31], 8'hFF, 23'b0};
    else if (e <= 10'sd0)                                   out = {x[31], 31'b0};
    else                                                    out = {x[31], e[7:0], frac};
  end

endmodule

// File: rtl/float_mult.sv
// Combinational FP32 multiplier, round-to-nearest-even.
// Subnormal inputs are treated as zero and underflow flushes to signed zero.
module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  logic              s;
  logic [47:0]       p;
  logic [22:0]       frac;
  logic              g;
  logic              st;
  logic              rnd;
  logic [23:0]       m;
  logic signed [9:0] e;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (&a[30:23]) & (|a[22:0]);
  assign b_nan  = (&b[30:23]) & (|b[22:0]);
  assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
  assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
  assign a_zero = ~(|a[30:23]);
  assign b_zero = ~(|b[30:23]);

  always_comb begin
    s = a[31] ^ b[31];
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
        + $signed({9'b0, p[47]});
    if (p[47]) begin
      frac = p[46:24];
      g    = p[23];
      st   = |p[22:0];
    end else begin
      frac = p[45:23];
      g    = p[22];
      st   = |p[21:0];
    end
    rnd = g & (st | frac[0]);
    m   = {1'b0, frac} + {23'b0, rnd};
    if (m[23]) e = e + 10'sd1;

    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) out = 32'h7FC00000;
    else if (a_inf | b_inf)                                  out = {s, 8'hFF, 23'b0};
    else if (a_zero | b_zero)                                out = {s, 31'b0};
    else if (e >= 10'sd255)                                  out = {s, 8'hFF, 23'b0};
    else if (e <= 10'sd0)                                    out = {s, 31'b0};
    else                                                     out = {s, e[7:0], m[22:0]};
  end

endmodule

// File: rtl/relu_fp32.sv
// FP32 ReLU: any value with the sign bit set (including -0 and negative NaN) becomes +0.
module relu_fp32
  import node_pkg::*;
(
  input  logic [FP32_W-1:0] x,
  output logic [FP32_W-1:0] y
);

  assign y = x[FP32_W-1] ? '0 : x;

endmodule

// File: rtl/node_mac_seq.sv
// Sequential FP32 neuron: one multiplier and one adder shared over N_IN terms,
// summed in order ((B+p0)+p1)+... and clamped by ReLU.
module node_mac_seq
  import node_pkg::*;
#(
  parameter int                         N_IN  = 15,
  parameter logic [N_IN*FP32_W-1:0]     W_VEC = NODE_W,
  parameter logic [FP32_W-1:0]          B_VAL = NODE_B
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [$clog2(N_IN)-1:0]       a_idx,
  input  logic [FP32_W-1:0]             a_data,
  input  logic                          a_valid,
  output logic                          busy,
  output logic                          done,
  output logic [FP32_W-1:0]             N1
);

  localparam int              AW   = $clog2(N_IN);
  localparam logic [AW-1:0]   LAST = AW'(N_IN - 1);

  state_t              state, state_nxt;
  logic [AW-1:0]       k;
  logic                pv;
  logic [FP32_W-1:0]   acc, prod;
  logic [FP32_W-1:0]   w_sel, prod_nxt, sum, relu_out;

  assign w_sel = W_VEC[int'(k)*FP32_W +: FP32_W];

  float_mult u_mult (
    .a   (a_data),
    .b   (w_sel),
    .out (prod_nxt)
  );

  float_adder u_add (
    .a        (acc),
    .b        (prod),
    .out      (sum),
    .Out_test (),
    .shift    (),
    .c_out    ()
  );

  relu_fp32 u_relu (
    .x (sum),
    .y (relu_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (a_valid && k == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_idx = (state == RUN) ? k : '0;
  end

  // Datapath: a pending product is folded into acc at the same edge a new one is captured.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
    if (!rst_n) begin
      k    <= '0;
      pv   <= 1'b0;
      acc  <= '0;
      prod <= '0;
      N1   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc  <= B_VAL;
            k    <= '0;
            pv   <= 1'b0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          if (pv) acc <= sum;
          pv <= a_valid;
          if (a_valid) begin
            prod <= prod_nxt;
            k    <= (k == LAST) ? '0 : k + 1'b1;
          end
        end
        DRAIN: begin
          N1   <= relu_out;
          done <= 1'b1;
          pv   <= 1'b0;
        end
        FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_mac_seq.sv
// Bench for node_mac_seq: three instances (unit weights, unit weights with -16 bias,
// default weights) share control; a double-precision FP32 model feeds scoreboards.
module tb_node_mac_seq;
  import node_pkg::*;

  localparam int              N      = NODE_N;
  localparam logic [31:0]     ONE    = 32'h3F800000;
  localparam logic [N*32-1:0] W_ONES = {N{ONE}};
  localparam logic [31:0]     B_NEG  = 32'hC1800000;

  typedef struct {
    logic [31:0] act;
    logic [31:0] exp_one;
    logic [31:0] exp_neg;
    int          stall_at;
    int          stall_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        a_valid = 1'b0;
  logic [3:0]  idx_one, idx_neg, idx_def;
  logic [31:0] ad_one, ad_neg, ad_def;
  logic [31:0] n1_one, n1_neg, n1_def;
  logic        busy_one, busy_neg, busy_def;
  logic        done_one, done_neg, done_def;

  logic [31:0] act_one [16];
  logic [31:0] act_def [16];
  logic [31:0] w_one   [16];
  logic [31:0] w_def   [16];

  logic [31:0] sb_one [$];
  logic [31:0] sb_neg [$];
  logic [31:0] sb_def [$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int nd_one = 0;
  int nd_neg = 0;
  int nd_def = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ad_one = act_one[idx_one];
  assign ad_neg = act_one[idx_neg];
  assign ad_def = act_def[idx_def];

  node_mac_seq #(.N_IN(N), .W_VEC(W_ONES), .B_VAL(32'h0)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start), .a_idx(idx_one), .a_data(ad_one),
    .a_valid(a_valid), .busy(busy_one), .done(done_one), .N1(n1_one)
  );

  node_mac_seq #(.N_IN(N), .W_VEC(W_ONES), .B_VAL(B_NEG)) u_neg (
    .clk(clk), .rst_n(rst_n), .start(start), .a_idx(idx_neg), .a_data(ad_neg),
    .a_valid(a_valid), .busy(busy_neg), .done(done_neg), .N1(n1_neg)
  );

  node_mac_seq u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .a_idx(idx_def), .a_data(ad_def),
    .a_valid(a_valid), .busy(busy_def), .done(done_def), .N1(n1_def)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference arithmetic: FP32 operands widened to double, result rounded back to
  // FP32 nearest-even. Double has enough precision that this is correctly rounded.
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e11;
    e11 = 11'(x[30:23]) + 11'd896;
    if (x[30:23] == 8'd0) d = {x[31], 63'b0};
    else                  d = {x[31], e11, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rem;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'b0};
    e   = int'(d[62:52]) - 896;
    m   = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      e = e + 1;
      m = m >> 1;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return to_fp32(to_real(a) * to_real(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return to_fp32(to_real(a) + to_real(b));
  endfunction

  function automatic logic [31:0] model(input logic [31:0] w [16], input logic [31:0] b,
                                        input logic [31:0] a [16]);
    logic [31:0] acc;
    acc = b;
    for (int i = 0; i < N; i++) acc = fadd(acc, fmul(a[i], w[i]));
    return acc[31] ? 32'h0 : acc;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(120, 134));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (done_one) begin
      nd_one++;
      check("sb_one_pending", 32'(sb_one.size() != 0), 32'd1);
      if (sb_one.size() != 0) check("n1_one", n1_one, sb_one.pop_front());
    end
    if (done_neg) begin
      nd_neg++;
      check("sb_neg_pending", 32'(sb_neg.size() != 0), 32'd1);
      if (sb_neg.size() != 0) check("n1_neg", n1_neg, sb_neg.pop_front());
    end
    if (done_def) begin
      nd_def++;
      check("sb_def_pending", 32'(sb_def.size() != 0), 32'd1);
      if (sb_def.size() != 0) check("n1_def", n1_def, sb_def.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] e_one, input logic [31:0] e_neg);
    sb_one.push_back(e_one);
    sb_neg.push_back(e_neg);
    sb_def.push_back(model(w_def, NODE_B, act_def));
  endtask

  task automatic wait_done(input int stall_at, input int stall_len);
    int guard;
    int left;
    guard = 0;
    left  = stall_len;
    while (!done_one && guard < 200) begin
      if (left > 0 && int'(idx_one) == stall_at) begin
        a_valid = 1'b0;
        left--;
      end else begin
        a_valid = 1'b1;
      end
      tick();
      guard++;
      if (!a_valid) check("stall_idx_hold", 32'(idx_one), 32'(stall_at));
    end
    a_valid = 1'b1;
    if (!done_one) check("done_timeout", {31'b0, done_one}, 32'd1);
  endtask

  task automatic run_eval(input int stall_at, input int stall_len, input bit hold,
                          output int lat);
    int t0;
    start   = 1'b1;
    a_valid = 1'b1;
    tick();
    t0 = cyc;
    if (!hold) start = 1'b0;
    wait_done(stall_at, stall_len);
    lat = cyc - t0;
  endtask

  initial begin
    vec_t            vecs [6];
    logic [N*32-1:0] wv;
    int              lat;
    int              d0;
    int              g;
    int              sa, sl;

    vecs[0] = '{ONE,          32'h41700000, 32'h00000000, -1, 0};
    vecs[1] = '{ONE,          32'h41700000, 32'h00000000,  5, 3};
    vecs[2] = '{32'h40000000, 32'h41F00000, 32'h41600000, -1, 0};
    vecs[3] = '{32'hBF800000, 32'h00000000, 32'h00000000,  2, 1};
    vecs[4] = '{32'h3F000000, 32'h40F00000, 32'h00000000, 14, 2};
    vecs[5] = '{32'h40800000, 32'h42700000, 32'h42300000,  0, 1};

    wv = NODE_W;
    for (int i = 0; i < 16; i++) begin
      w_one[i]   = (i < N) ? ONE : 32'h0;
      w_def[i]   = (i < N) ? wv[32*i +: 32] : 32'h0;
      act_one[i] = 32'h0;
      act_def[i] = 32'h0;
    end

    // Reset state
    tick();
    tick();
    check("rst_busy_one", {31'b0, busy_one}, 32'd0);
    check("rst_done_one", {31'b0, done_one}, 32'd0);
    check("rst_n1_one",   n1_one, 32'h0);
    check("rst_idx_one",  32'(idx_one), 32'd0);
    check("rst_busy_def", {31'b0, busy_def}, 32'd0);
    check("rst_n1_def",   n1_def, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven evaluations with constant activations
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) begin
        act_one[i] = vecs[v].act;
        act_def[i] = rand_fp();
      end
      push(vecs[v].exp_one, vecs[v].exp_neg);
      run_eval(vecs[v].stall_at, vecs[v].stall_len, 1'b0, lat);
      check("latency", 32'(lat), 32'(16 + vecs[v].stall_len));
      tick();
      check("done_one_pulse", {31'b0, done_one}, 32'd0);
      check("done_neg_pulse", {31'b0, done_neg}, 32'd0);
      check("busy_one_fin",   {31'b0, busy_one}, 32'd0);
      check("busy_def_fin",   {31'b0, busy_def}, 32'd0);
      check("n1_one_hold",    n1_one, vecs[v].exp_one);
      check("n1_neg_hold",    n1_neg, vecs[v].exp_neg);
      tick();
    end

    // Random activations against the sequential-order model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        act_one[i] = rand_fp();
        act_def[i] = rand_fp();
      end
      sa = $urandom_range(0, N - 1);
      sl = $urandom_range(0, 2);
      push(model(w_one, 32'h0, act_one), model(w_one, B_NEG, act_one));
      run_eval(sa, sl, 1'b0, lat);
      check("rand_latency", 32'(lat), 32'(16 + sl));
      tick();
      tick();
    end

    // start held high through a whole evaluation: no queuing in FIN
    for (int i = 0; i < N; i++) act_one[i] = ONE;
    d0 = nd_one;
    push(32'h41700000, 32'h0);
    run_eval(-1, 0, 1'b1, lat);
    tick();
    check("fin_busy_low", {31'b0, busy_one}, 32'd0);
    check("fin_done_low", {31'b0, done_one}, 32'd0);
    push(32'h41700000, 32'h0);
    tick();
    check("restart_busy", {31'b0, busy_one}, 32'd1);
    start = 1'b0;
    wait_done(-1, 0);
    tick();
    tick();
    tick();
    check("one_done_per_eval", 32'(nd_one - d0), 32'd2);
    check("idle_after_pair",   {31'b0, busy_one}, 32'd0);

    // Reset in the middle of an evaluation
    push(32'h41700000, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (idx_one != 4'd7 && g < 50) begin
      tick();
      g++;
    end
    check("reach_idx7", 32'(idx_one), 32'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_one.delete();
    sb_neg.delete();
    sb_def.delete();
    check("mid_rst_busy", {31'b0, busy_one}, 32'd0);
    check("mid_rst_n1",   n1_one, 32'h0);
    check("mid_rst_done", {31'b0, done_one}, 32'd0);
    check("mid_rst_idx",  32'(idx_one), 32'd0);
    d0 = nd_one;
    repeat (20) tick();
    check("no_done_after_rst", 32'(nd_one - d0), 32'd0);
    push(32'h41700000, 32'h0);
    run_eval(-1, 0, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd16);
    tick();
    tick();

    check("sb_drained", 32'(sb_one.size() + sb_neg.size() + sb_def.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
